// File: rtl/bundle_sequencer_if.sv
// rtl/bundle_sequencer_if.sv - command, beat, counter-control and result signals of the bundle sequencer
interface bundle_sequencer_if #(
  parameter int LANES = 32,
  parameter int CORES = 4,
  parameter int W     = 30
);
  logic             start;
  logic [W-1:0]     item_num;
  logic             seed_we;
  logic [31:0]      seed;
  logic             in_valid;
  logic             in_ready;
  logic             cnt_clr;
  logic             cnt_even;
  logic [LANES-1:0] cnt_rand_bit;
  logic             cnt_update;
  logic [CORES-1:0] cnt_core_enable;
  logic [LANES-1:0] cnt_sign;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_data;
  logic             busy;
  logic             done;

  modport slave (
    input  start, item_num, seed_we, seed, in_valid, cnt_sign, out_ready,
    output in_ready, cnt_clr, cnt_even, cnt_rand_bit, cnt_update, cnt_core_enable,
           out_valid, out_data, busy, done
  );

  modport master (
    output start, item_num, seed_we, seed, in_valid, cnt_sign, out_ready,
    input  in_ready, cnt_clr, cnt_even, cnt_rand_bit, cnt_update, cnt_core_enable,
           out_valid, out_data, busy, done
  );
endinterface

// File: rtl/bundle_sequencer.sv
// rtl/bundle_sequencer.sv - per-job controller for a bank of majority counters
module bundle_sequencer #(
  parameter int LANES = 32,
  parameter int CORES = 4,
  parameter int W     = 30,
  parameter int LAT   = 2
) (
  input  logic clk,
  input  logic rst_n,
  bundle_sequencer_if.slave bus
);

  localparam int DW = $clog2(LAT + 2);
  localparam logic [W-1:0] CORES_W = W'(CORES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_step;
  logic [W-1:0]     rem;
  logic             even_q;
  logic [DW-1:0]    drain_cnt;
  logic             drain_last;
  logic [LANES-1:0] out_q;
  logic [CORES-1:0] mask;
  logic             beat;
  logic             last_beat;

  assign lfsr_step  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign beat       = bus.in_valid && (state == S_ACCUM);
  assign last_beat  = beat && (rem <= CORES_W);
  assign drain_last = (state == S_DRAIN) && (drain_cnt == DW'(LAT));

  // Core i contributes only while at least i+1 items remain.
  always_comb begin
    mask = '0;
    for (int i = 0; i < CORES; i++) begin
      mask[i] = (W'(i) < rem);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = (rem != '0) ? S_ACCUM : S_DRAIN;
      S_ACCUM:  if (last_beat) state_nx = S_DRAIN;
      S_DRAIN:  if (drain_last) state_nx = S_OUTPUT;
      S_OUTPUT: if (bus.out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= 32'hACE1_ACE1;
      rem       <= '0;
      even_q    <= 1'b0;
      drain_cnt <= '0;
      out_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        // A seed write wins over the step that start would otherwise cause.
        if (bus.seed_we) begin
          lfsr <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
        end else if (bus.start) begin
          lfsr <= lfsr_step;
        end
        if (bus.start) begin
          rem    <= bus.item_num;
          even_q <= ~bus.item_num[0];
        end
      end
      if (beat) begin
        rem <= last_beat ? '0 : rem - CORES_W;
      end
      drain_cnt <= ((state == S_DRAIN) && !drain_last) ? drain_cnt + 1'b1 : '0;
      if (drain_last) begin
        out_q <= bus.cnt_sign;
      end
    end
  end

  assign bus.in_ready        = (state == S_ACCUM);
  assign bus.cnt_update      = beat;
  assign bus.cnt_core_enable = (state == S_ACCUM) ? mask : '0;
  assign bus.cnt_clr         = (state == S_CLEAR);
  assign bus.cnt_even        = (state == S_CLEAR) && even_q;
  assign bus.cnt_rand_bit    = (state == S_CLEAR) ? lfsr[LANES-1:0] : '0;
  assign bus.out_valid       = (state == S_OUTPUT);
  assign bus.out_data        = out_q;
  assign bus.busy            = (state != S_IDLE);
  assign bus.done            = (state == S_OUTPUT) && bus.out_ready;

endmodule
